seq_frame_tx: RTL

//  Serial frame transmitter for the 10101 sequence-detector link. Accepts a parallel payload
//  via a valid/ready handshake and emits, one bit per clk, a sync preamble (default 10101),

---
 rtl/seq_frame_tx_pkg.sv | 15 +
 rtl/seq_piso.sv | 30 +++
 rtl/seq_frame_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seq_frame_tx_pkg.sv
// Shared definitions for the 10101 sequence link: transmitter state encoding
// and default preamble settings used by both the transmitter and the detector.
package seq_frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_PAR  = 2'd3
    } tx_state_e;

    localparam int         SEQ_PRE_W_DEF    = 5;
    localparam logic [4:0] SEQ_PREAMBLE_DEF = 5'b10101;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, MSB-first shift register feeding the frame transmitter payload phase.
module seq_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] shreg_r;

    // Payload holding register: load wins over shift, zero fill from the right.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_r <= '0;
        end else if (load) begin
            shreg_r <= din;
        end else if (shift) begin
            shreg_r <= shreg_r << 1'b1;
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign msb = shreg_r[DATA_W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble then MSB-first payload, one bit per clk.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx
    import seq_frame_tx_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               PRE_W    = SEQ_PRE_W_DEF,
    parameter logic [PRE_W-1:0] PREAMBLE = SEQ_PREAMBLE_DEF,
    parameter logic             IDLE_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W  = $clog2((PRE_W > DATA_W) ? PRE_W : DATA_W) + 1;
    localparam int PIDX_W = $clog2(PRE_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);

`ifdef SEQ_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
    logic par_r;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    // A 1-bit payload without parity makes the first data bit the last frame bit.
    localparam logic DONE_AT_PRE = (DATA_W == 1) && !PAR_EN;

    tx_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_dec_s;
    logic             accept_s;
    logic             shift_s;
    logic             msb_s;

    assign cnt_dec_s = cnt_r - CNT_ONE;
    assign accept_s  = (state_r == ST_IDLE) && din_valid && din_ready;
    assign shift_s   = ((state_r == ST_PRE) && (cnt_r == '0)) ||
                       ((state_r == ST_DATA) && (cnt_r != '0));

    seq_piso #(.DATA_W(DATA_W)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (accept_s),
        .shift (shift_s),
        .din   (din),
        .msb   (msb_s)
    );

    // Frame FSM; cnt_r is the index of the bit currently on dout within its phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            dout       <= IDLE_LVL;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            din_ready  <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
            par_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r    <= ST_PRE;
                        cnt_r      <= PRE_LOAD;
                        dout       <= PREAMBLE[PRE_W-1];
                        dout_valid <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        din_ready  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
                        par_r      <= ^din;
`endif
                    end else begin
                        cnt_r      <= '0;
                        dout       <= IDLE_LVL;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        din_ready  <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (cnt_r == '0) begin
                        state_r <= ST_DATA;
                        cnt_r   <= DATA_LOAD;
                        dout    <= msb_s;
                        done    <= DONE_AT_PRE;
                    end else begin
                        cnt_r   <= cnt_dec_s;
                        dout    <= PREAMBLE[cnt_dec_s[PIDX_W-1:0]];
                        done    <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == '0) begin
`ifdef SEQ_TX_PARITY_EN
                        state_r <= ST_PAR;
                        cnt_r   <= '0;
                        dout    <= par_r;
                        done    <= 1'b1;
`else
                        state_r    <= ST_IDLE;
                        cnt_r      <= '0;
                        dout       <= IDLE_LVL;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        din_ready  <= 1'b1;
`endif
                    end else begin
                        cnt_r <= cnt_dec_s;
                        dout  <= msb_s;
                        done  <= (cnt_r == CNT_ONE) && !PAR_EN;
                    end
                end
`ifdef SEQ_TX_PARITY_EN
                ST_PAR: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= '0;
                    dout       <= IDLE_LVL;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    din_ready  <= 1'b1;
                end
`endif
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= '0;
                    dout       <= IDLE_LVL;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    din_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
